// File: rtl/mat_vec_mult_seq_if.sv
// Start/end handshake bundle for the sequential matrix-vector multiplier.
// The initiator drives operands and startMult; the responder returns Res.
interface mat_vec_mult_seq_if #(
    parameter int WIDTH = 16,
    parameter int nos   = 4
);
    logic                               startMult;
    logic [nos-1:0][nos-1:0][WIDTH-1:0] A;
    logic [nos-1:0][WIDTH-1:0]          B;
    logic [nos-1:0][WIDTH-1:0]          Res;
    logic                               endMult;
    logic                               busy;

    modport master (
        output startMult, A, B,
        input  Res, endMult, busy
    );

    modport slave (
        input  startMult, A, B,
        output Res, endMult, busy
    );
endinterface

// File: rtl/mat_vec_mult_seq.sv
// Sequential fixed-point Res = A x B, one signed MAC lane per row.
// Each lane consumes one column per enabled cycle; operands latched at start.
module mat_vec_mult_seq #(
    parameter int WIDTH     = 16,
    parameter int nos       = 4,
    parameter int intDigits = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    mat_vec_mult_seq_if.slave bus
);
    localparam int FRAC = WIDTH - intDigits;
    localparam int CW   = $clog2(nos);
    localparam int PW   = 2 * WIDTH;
    localparam int AW   = PW + CW;
    localparam logic [CW-1:0] LAST = CW'(nos - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [nos-1:0][nos-1:0][WIDTH-1:0] ar;
    logic [nos-1:0][WIDTH-1:0]          br;
    logic [nos-1:0][WIDTH-1:0]          res_q;
    logic [nos-1:0][WIDTH-1:0]          res_nxt;
    logic [CW-1:0]                      col;

    logic signed [AW-1:0] acc     [nos];
    logic signed [AW-1:0] acc_nxt [nos];
    logic signed [PW-1:0] a_ext   [nos];
    logic signed [PW-1:0] prod    [nos];
    logic signed [PW-1:0] b_ext;

    logic start_run;
    logic last_col;

    assign last_col = (state == RUN) && (col == LAST);

    // State register; reset and every transition wait for an enabled edge.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                state <= IDLE;
            end else begin
                state <= state_nxt;
            end
        end
    end

    // Next-state decode: start only accepted in IDLE, DONE lasts one cycle.
    always_comb begin
        state_nxt = state;
        start_run = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.startMult) begin
                    state_nxt = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (last_col) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // MAC lanes: product of current column, next accumulator and scaled result.
    always_comb begin
        b_ext = PW'($signed(br[col]));
        for (int i = 0; i < nos; i++) begin
            a_ext[i]   = PW'($signed(ar[i][col]));
            prod[i]    = a_ext[i] * b_ext;
            acc_nxt[i] = acc[i] + AW'(prod[i]);
            res_nxt[i] = WIDTH'(acc_nxt[i] >>> FRAC);
        end
    end

    // Operand latch, accumulation and result load including the final MAC.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                ar    <= '0;
                br    <= '0;
                col   <= '0;
                res_q <= '0;
                for (int i = 0; i < nos; i++) begin
                    acc[i] <= '0;
                end
            end else if (start_run) begin
                ar  <= bus.A;
                br  <= bus.B;
                col <= '0;
                for (int i = 0; i < nos; i++) begin
                    acc[i] <= '0;
                end
            end else if (state == RUN) begin
                for (int i = 0; i < nos; i++) begin
                    acc[i] <= acc_nxt[i];
                end
                if (last_col) begin
                    col   <= '0;
                    res_q <= res_nxt;
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign bus.Res     = res_q;
    assign bus.endMult = (state == DONE);
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_mat_vec_mult_seq.sv
// Bench for mat_vec_mult_seq: integer-only and 8.8 instances, shared stimulus.
// Transaction-level model plus directed literal checks.
module tb_mat_vec_mult_seq;
    localparam int W = 16;
    localparam int N = 4;

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
    typedef logic [N-1:0][W-1:0]        vec_t;

    logic clk = 1'b0;
    logic reset;
    logic clk_en;
    logic start;
    mat_t a_drv;
    vec_t b_drv;
    logic chk_on = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mat_vec_mult_seq_if #(.WIDTH(W), .nos(N)) bus16 ();
    mat_vec_mult_seq_if #(.WIDTH(W), .nos(N)) bus8 ();

    assign bus16.startMult = start;
    assign bus16.A         = a_drv;
    assign bus16.B         = b_drv;
    assign bus8.startMult  = start;
    assign bus8.A          = a_drv;
    assign bus8.B          = b_drv;

    mat_vec_mult_seq #(.WIDTH(W), .nos(N), .intDigits(16)) dut16 (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus16.slave)
    );

    mat_vec_mult_seq #(.WIDTH(W), .nos(N), .intDigits(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .bus    (bus8.slave)
    );

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Plain integer matrix-vector product, floor-scaled and wrapped.
    function automatic vec_t mvm(input mat_t a, input vec_t b, input int frac);
        vec_t   r;
        longint s;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) begin
                s += longint'($signed(a[i][j])) * longint'($signed(b[j]));
            end
            r[i] = W'(s >>> frac);
        end
        return r;
    endfunction

    // Model: a run is a countdown of nos+1 enabled edges; result shows at 1.
    int   m_rem = 0;
    vec_t m_pend16, m_pend8;
    vec_t m_res16 = '0;
    vec_t m_res8  = '0;

    always @(posedge clk) begin
        if (clk_en) begin
            if (reset) begin
                m_rem   = 0;
                m_res16 = '0;
                m_res8  = '0;
            end else if (m_rem == 0) begin
                if (start) begin
                    m_pend16 = mvm(a_drv, b_drv, 0);
                    m_pend8  = mvm(a_drv, b_drv, 8);
                    m_rem    = N + 1;
                end
            end else begin
                m_rem--;
                if (m_rem == 1) begin
                    m_res16 = m_pend16;
                    m_res8  = m_pend8;
                end
            end
        end
    end

    // Cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("busy16", 64'(bus16.busy), 64'(m_rem > 0));
            check("end16", 64'(bus16.endMult), 64'(m_rem == 1));
            check("res16", bus16.Res, m_res16);
            check("busy8", 64'(bus8.busy), 64'(m_rem > 0));
            check("end8", 64'(bus8.endMult), 64'(m_rem == 1));
            check("res8", bus8.Res, m_res8);
        end
    end

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!bus16.endMult && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input mat_t a, input vec_t b, output int n);
        a_drv = a;
        b_drv = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, n);
    endtask

    mat_t ma, mb;
    vec_t va, vb;
    int   n;
    int   ends;

    initial begin
        start  = 1'b0;
        reset  = 1'b1;
        clk_en = 1'b1;
        a_drv  = '0;
        b_drv  = '0;
        repeat (2) @(negedge clk);
        check("rst_res16", bus16.Res, 64'h0);
        check("rst_end16", 64'(bus16.endMult), 64'h0);
        check("rst_busy16", 64'(bus16.busy), 64'h0);
        reset  = 1'b0;
        chk_on = 1'b1;

        // identity
        ma = '0;
        for (int i = 0; i < N; i++) ma[i][i] = 16'd1;
        va = {16'd4, 16'd3, 16'd2, 16'd1};
        run(ma, va, n);
        check("t1_lat", 64'(n), 64'd5);
        check("t1_res", bus16.Res, 64'h0004_0003_0002_0001);
        @(negedge clk);
        check("t1_idle_end", 64'(bus16.endMult), 64'h0);
        check("t1_idle_busy", 64'(bus16.busy), 64'h0);

        // signed
        ma = '0;
        ma[0][0] = 16'hFFFF;
        ma[0][1] = 16'd2;
        for (int j = 0; j < N; j++) ma[1][j] = 16'd1;
        va = {16'd6, 16'd5, 16'hFFFC, 16'd3};
        run(ma, va, n);
        check("t2_lat", 64'(n), 64'd5);
        check("t2_res", bus16.Res, 64'h0000_0000_000A_FFF5);
        @(negedge clk);

        // fraction on the 8.8 instance
        ma = '0;
        ma[0][0] = 16'h0180;
        ma[1][1] = 16'hFF80;
        va = '0;
        va[0] = 16'h0200;
        va[1] = 16'h0001;
        run(ma, va, n);
        check("t3_res8", bus8.Res, 64'h0000_0000_FFFF_0300);
        @(negedge clk);

        // wrap
        ma = '0;
        ma[0][0] = 16'h7FFF;
        va = '0;
        va[0] = 16'd2;
        run(ma, va, n);
        check("t4_lat", 64'(n), 64'd5);
        check("t4_res", bus16.Res, 64'h0000_0000_0000_FFFE);
        @(negedge clk);

        // latch and ignore
        ma = '0;
        for (int i = 0; i < N; i++) ma[i][i] = 16'd2;
        va = {16'd8, 16'd7, 16'd6, 16'd5};
        a_drv = ma;
        b_drv = va;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) a_drv[i][j] = 16'h1234;
        b_drv = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(3, n);
        check("t5_lat", 64'(n), 64'd5);
        check("t5_res", bus16.Res, 64'h0010_000E_000C_000A);
        @(negedge clk);
        check("t5_no_second", 64'(bus16.endMult), 64'h0);
        check("t5_idle", 64'(bus16.busy), 64'h0);
        ma = '0;
        for (int i = 0; i < N; i++) ma[i][i] = 16'd1;
        va = {16'd4, 16'd3, 16'd2, 16'd1};
        run(ma, va, n);
        check("t5_rerun_lat", 64'(n), 64'd5);
        check("t5_rerun_res", bus16.Res, 64'h0004_0003_0002_0001);
        @(negedge clk);

        // clock-enable stall
        ma = '0;
        for (int i = 0; i < N; i++) ma[i][i] = 16'd3;
        va = {16'd1, 16'd1, 16'd1, 16'd1};
        a_drv = ma;
        b_drv = va;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        wait_done(5, n);
        check("t6_stall_lat", 64'(n), 64'd8);
        check("t6_stall_res", bus16.Res, 64'h0003_0003_0003_0003);
        @(negedge clk);

        // reset mid-run
        va = {16'd2, 16'd2, 16'd2, 16'd2};
        b_drv = va;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_rst_busy", 64'(bus16.busy), 64'h0);
        check("t6_rst_res16", bus16.Res, 64'h0);
        check("t6_rst_res8", bus8.Res, 64'h0);
        ends = 0;
        repeat (6) begin
            if (bus16.endMult) ends++;
            @(negedge clk);
        end
        check("t6_rst_no_end", 64'(ends), 64'h0);

        // random traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) a_drv[i][j] = W'($urandom);
                b_drv[i] = W'($urandom);
            end
            start  = ($urandom_range(0, 2) == 0);
            clk_en = ($urandom_range(0, 9) != 0);
            reset  = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        start  = 1'b0;
        reset  = 1'b0;
        clk_en = 1'b1;
        repeat (8) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
